// File: rtl/sumador_pkg.sv
// Shared definitions for the multi-word adder sequencer: controller states,
// default geometry and the helper that sizes the chunk index register.
package sumador_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   localparam int N_DEF = 8;
   localparam int K_DEF = 4;

   // A single-chunk configuration still needs a 1-bit index so the register exists
   function automatic int idxWidth(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/sumadorNBits.sv
// Plain N-bit ripple adder with carry in/out; the only combinational
// arithmetic in the multi-word datapath.
module sumadorNBits #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] s,
   output logic         c_out
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/sumador_multipalabra_ctrl.sv
// Adds two W = N*K bit operands by walking one shared N-bit adder over K
// chunks, least-significant first, with the carry kept in a register.
module sumador_multipalabra_ctrl
   import sumador_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N*K-1:0] a,
   input  logic [N*K-1:0] b,
   input  logic           c_in,
   output logic           busy,
   output logic           done,
   output logic [N*K-1:0] s,
   output logic           c_out
);

   localparam int W  = N * K;
   localparam int IW = idxWidth(K);
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic [W-1:0]  opA_q;
   logic [W-1:0]  opB_q;
   logic [W-1:0]  work_q;
   logic [W-1:0]  work_d;
   logic [W-1:0]  s_q;
   logic          cOut_q;
   logic          done_q;
   logic          busy_q;

   logic [N-1:0]  chunkA;
   logic [N-1:0]  chunkB;
   logic [N-1:0]  chunkSum;
   logic          chunkCarry;

   assign chunkA = opA_q[int'(idx_q) * N +: N];
   assign chunkB = opB_q[int'(idx_q) * N +: N];

   sumadorNBits #(
      .N(N)
   ) uAdder (
      .a    (chunkA),
      .b    (chunkB),
      .c_in (carry_q),
      .s    (chunkSum),
      .c_out(chunkCarry)
   );

   // The final chunk lands on the same edge that publishes the sum, so the
   // published value is the work register with the current chunk merged in.
   always_comb begin
      work_d = work_q;
      work_d[int'(idx_q) * N +: N] = chunkSum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opA_q   <= '0;
         opB_q   <= '0;
         work_q  <= '0;
         s_q     <= '0;
         cOut_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  opA_q   <= a;
                  opB_q   <= b;
                  carry_q <= c_in;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ADD;
               end
            end
            ADD: begin
               work_q  <= work_d;
               carry_q <= chunkCarry;
               if (idx_q == LAST_IDX) begin
                  s_q     <= work_d;
                  cOut_q  <= chunkCarry;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign s     = s_q;
   assign c_out = cOut_q;

endmodule

// File: doc/sumador_multipalabra_ctrl.md
Name: sumador_multipalabra_ctrl

Overview:
Sequencer that performs W-bit addition (W = N*K) by time-multiplexing one N-bit adder (sumadorNBits) over K cycles, least-significant chunk first. It latches wide operands on a start handshake and propagates carry between chunks in a register. It returns a registered W-bit sum and carry-out with a one-cycle done pulse. It sits between a host/control FSM and the shared adder datapath.

Parameters:
N, 8, chunk width in bits, i.e. the width of the shared adder; N >= 1.
K, 4, number of chunks; K >= 1, so W = N*K (32 by default).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only on a clk edge where busy=0.
a  input  W  operand A; sampled on the accepting edge.
b  input  W  operand B; sampled on the accepting edge.
c_in  input  1  initial carry; sampled on the accepting edge.
busy  output  1  high while an operation is in progress (states ADD and DONE).
done  output  1  one-cycle pulse; s/c_out are valid when it is high.
s  output  W  registered sum; held until the next result is written.
c_out  output  1  registered final carry; held with s.

Behaviour:
- Reset, asynchronous and checked first: state=IDLE, idx=0, carry reg=0, operand regs=0, work reg=0, s=0, c_out=0, done=0, busy=0.
- States and transitions:
  - IDLE: busy=0, done=0. On start=1, latch a, b and c_in (into carry reg), set idx=0, go to ADD.
  - ADD: busy=1.
    - Adder inputs are opA[idx*N +: N], opB[idx*N +: N] and the carry reg.
    - Each edge: work[idx*N +: N] <= adder sum; carry reg <= adder carry-out.
    - If idx==K-1, go to DONE; otherwise idx <= idx+1.
  - DONE: on entry, s <= completed work reg and c_out <= final carry. done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge E0. ADD occupies edges E1..EK. done=1 in the cycle following EK. Total K+1 cycles; the next start is accepted at edge E(K+2). K=1 therefore gives 2 cycles.
- s and c_out change only on entry to DONE or on reset. They stay stable during a subsequent operation until its DONE.
- start while busy=1 is ignored and not queued. Changes on a, b or c_in while busy have no effect.
- start held high continuously re-triggers a new operation at every accepting edge in IDLE, using the operand values present at that edge.
- Arithmetic is unsigned modulo 2^W. c_out is bit W of a+b+c_in.
- Overflow / wrap: an all-ones operand plus 1 must ripple through every chunk, taking K cycles, and give s=0, c_out=1.
- Reset mid-operation aborts immediately: no done pulse, outputs zeroed, controller ready for start on the first edge after rst deasserts.
- idx width is max(1, $clog2(K)). idx never exceeds K-1.
- Only the shared adder is combinational. All outputs are registered; none is driven combinationally from inputs.

Decomposition:
- Shared package sumador_pkg:
  - state enum {IDLE, ADD, DONE}.
  - localparam defaults N_DEF=8, K_DEF=4.
  - function computing idx width.
- Sub-module: one instance of the existing sumadorNBits #(N) as the datapath. Its inputs are mux-selected chunks plus the carry reg; the controller holds no other arithmetic.

Test Plan:
(N=8, K=4; check done exactly 5 cycles after the accepting edge, and exactly one pulse.)
1. a=0x00000005, b=0x00000003, c_in=0 -> s=0x00000008, c_out=0; busy high 5 cycles.
2. a=0xFFFFFFFF, b=0x00000001, c_in=0 -> s=0x00000000, c_out=1 (carry through all 4 chunks).
3. a=0x00FF00FF, b=0x00010001, c_in=1 -> s=0x01000101, c_out=0. Also a=b=0xFFFFFFFF, c_in=1 -> s=0xFFFFFFFF, c_out=1.
4. Start with a=0x12345678, b=0x11111111, c_in=0. Pulse start again 2 cycles later with a=b=0 -> second start ignored; single done with s=0x23456789. s then holds 0x23456789 through the idle cycles and during the next operation until its done.
5. Assert rst after 2 ADD cycles of a=0xFFFFFFFF, b=0x1 -> immediately busy=0, done=0, s=0, c_out=0, no done pulse. After release, a=0x00000010, b=0x00000020 -> s=0x00000030.
6. Back-to-back: start held high for 12 cycles with the operand pairs below. Expect two done pulses, spaced 6 cycles apart.
   - First pair, sampled at the first accepting edge: a=1, b=1 -> s=0x00000002.
   - Second pair, present at the next accepting edge: a=0x80000000, b=0x80000000 -> s=0x00000000, c_out=1.
